// File: rtl/mem_access_unit_pkg.sv
// Shared types for the M memory interface and the load/store unit:
// M request/response structs, enable levels, access sizes and FSM states.
package mem_access_unit_pkg;

   localparam int MemAddrWidth = 8;

   localparam logic ENABLE  = 1'b1;
   localparam logic DISABLE = 1'b0;

   typedef struct packed {
      logic [31:0] addr;
      logic        read;
      logic        write;
      logic [31:0] val;
   } M_input;

   typedef struct packed {
      logic [31:0] val;
   } M_output;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2,
      SZ_ILL  = 2'd3
   } lsu_size_t;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_RD     = 3'd1,
      ST_RMW_RD = 3'd2,
      ST_RMW_WR = 3'd3,
      ST_WR     = 3'd4,
      ST_RESP   = 3'd5
   } lsu_state_t;

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Little-endian lane handling: extracts and extends load data from a word,
// and merges sub-word store data into a previously read word.
module lsu_lane_align
   import mem_access_unit_pkg::*;
(
   input  logic [31:0] rd_word,
   input  logic [31:0] merge_word,
   input  logic [1:0]  lane,
   input  lsu_size_t   size,
   input  logic        is_unsigned,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] store_word
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   assign byte_sel = rd_word[{lane, 3'b000} +: 8];
   assign half_sel = lane[1] ? rd_word[31:16] : rd_word[15:0];

   always_comb begin
      load_data = rd_word;
      case (size)
         SZ_BYTE: load_data = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
         SZ_HALF: load_data = {{16{~is_unsigned & half_sel[15]}}, half_sel};
         default: load_data = rd_word;
      endcase
   end

   always_comb begin
      store_word = merge_word;
      case (size)
         SZ_BYTE: store_word[{lane, 3'b000} +: 8] = wdata[7:0];
         SZ_HALF: begin
            if (lane[1]) store_word[31:16] = wdata[15:0];
            else         store_word[15:0]  = wdata[15:0];
         end
         SZ_WORD: store_word = wdata;
         default: store_word = merge_word;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator for the word-only M memory; sub-word stores use read-modify-write.
// Optional macro LSU_STATS_EN adds saturating load/store/fault completion counters.
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int unsigned ADDR_LIMIT = 4 * (2 ** MemAddrWidth)
`ifdef LSU_STATS_EN
   ,
   parameter int CNT_W = 16
`endif
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  lsu_size_t   req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_fault,
   output M_input      mem_out,
   input  M_output     mem_in
`ifdef LSU_STATS_EN
   ,
   output logic [CNT_W-1:0] stat_loads,
   output logic [CNT_W-1:0] stat_stores,
   output logic [CNT_W-1:0] stat_faults
`endif
);

   lsu_state_t  state;
   logic [31:0] addr_q;
   lsu_size_t   size_q;
   logic [31:0] wdata_q;
   logic        unsigned_q;
   logic [31:0] merge_q;
   logic [31:0] rdata_q;
   logic        fault_q;
   logic        req_fault;
   logic [31:0] load_data;
   logic [31:0] store_word;

   assign req_fault = (req_size == SZ_ILL)
                   || ((req_size == SZ_HALF) && req_addr[0])
                   || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00))
                   || (req_addr >= ADDR_LIMIT);

   lsu_lane_align u_align (
      .rd_word     (mem_in.val),
      .merge_word  (merge_q),
      .lane        (addr_q[1:0]),
      .size        (size_q),
      .is_unsigned (unsigned_q),
      .wdata       (wdata_q),
      .load_data   (load_data),
      .store_word  (store_word)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         addr_q     <= '0;
         size_q     <= SZ_BYTE;
         wdata_q    <= '0;
         unsigned_q <= 1'b0;
         merge_q    <= '0;
         rdata_q    <= '0;
         fault_q    <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  addr_q     <= req_addr;
                  size_q     <= req_size;
                  wdata_q    <= req_wdata;
                  unsigned_q <= req_unsigned;
                  rdata_q    <= '0;
                  fault_q    <= req_fault;
                  if (req_fault)                 state <= ST_RESP;
                  else if (!req_write)           state <= ST_RD;
                  else if (req_size == SZ_WORD)  state <= ST_WR;
                  else                           state <= ST_RMW_RD;
               end
            end
            ST_RD: begin
               rdata_q <= load_data;
               state   <= ST_RESP;
            end
            ST_RMW_RD: begin
               merge_q <= mem_in.val;
               state   <= ST_RMW_WR;
            end
            ST_RMW_WR, ST_WR: state <= ST_RESP;
            ST_RESP: if (rsp_ready) state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign req_ready = (state == ST_IDLE);
   assign rsp_valid = (state == ST_RESP);
   assign rsp_rdata = rdata_q;
   assign rsp_fault = fault_q;

   // M is word addressed in practice: the low address bits never reach it.
   always_comb begin
      mem_out.addr  = '0;
      mem_out.read  = DISABLE;
      mem_out.write = DISABLE;
      mem_out.val   = '0;
      case (state)
         ST_RD, ST_RMW_RD: begin
            mem_out.addr = {addr_q[31:2], 2'b00};
            mem_out.read = ENABLE;
         end
         ST_RMW_WR: begin
            mem_out.addr  = {addr_q[31:2], 2'b00};
            mem_out.write = ENABLE;
            mem_out.val   = store_word;
         end
         ST_WR: begin
            mem_out.addr  = {addr_q[31:2], 2'b00};
            mem_out.write = ENABLE;
            mem_out.val   = wdata_q;
         end
         default: ;
      endcase
   end

`ifdef LSU_STATS_EN
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   // Each counter steps on the edge that moves the FSM into RESP.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_loads  <= '0;
         stat_stores <= '0;
         stat_faults <= '0;
      end else begin
         if ((state == ST_IDLE) && req_valid && req_fault) stat_faults <= sat_inc(stat_faults);
         if (state == ST_RD) stat_loads <= sat_inc(stat_loads);
         if ((state == ST_WR) || (state == ST_RMW_WR)) stat_stores <= sat_inc(stat_stores);
      end
   end
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit against a word-array memory and a
// shift/mask reference model of loads, stores and faults.
module tb_mem_access_unit;
   import mem_access_unit_pkg::*;

   localparam int WORDS = 2 ** MemAddrWidth;
   localparam int LIMIT = 4 * WORDS;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   lsu_size_t   req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_fault;
   M_input      mem_out;
   M_output     mem_in;
`ifdef LSU_STATS_EN
   logic [15:0] stat_loads, stat_stores, stat_faults;
`endif

   logic [31:0] env_mem [WORDS];
   logic [31:0] ref_mem [WORDS];
   int total = 0;
   int bad = 0;
   int n_loads = 0, n_stores = 0, n_faults = 0;

   mem_access_unit dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_write    (req_write),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_rdata    (rsp_rdata),
      .rsp_fault    (rsp_fault),
      .mem_out      (mem_out),
      .mem_in       (mem_in)
`ifdef LSU_STATS_EN
      ,
      .stat_loads   (stat_loads),
      .stat_stores  (stat_stores),
      .stat_faults  (stat_faults)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // M: combinational read, write on the clock edge.
   assign mem_in.val = env_mem[mem_out.addr[MemAddrWidth+1:2]];
   always @(posedge clk) begin
      if (mem_out.write == ENABLE) env_mem[mem_out.addr[MemAddrWidth+1:2]] <= mem_out.val;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic ref_fault(input logic [1:0] sz, input logic [31:0] a);
      if (sz == 2'd3) return 1'b1;
      if (sz == 2'd1 && (a % 2) != 0) return 1'b1;
      if (sz == 2'd2 && (a % 4) != 0) return 1'b1;
      return a >= 32'(LIMIT);
   endfunction

   function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] sz,
                                            input logic u, input int sh);
      logic [31:0] v;
      v = w;
      if (sz == 2'd0) begin
         v = (w >> sh) & 32'h0000_00FF;
         if (!u && v[7]) v = v | 32'hFFFF_FF00;
      end else if (sz == 2'd1) begin
         v = (w >> sh) & 32'h0000_FFFF;
         if (!u && v[15]) v = v | 32'hFFFF_0000;
      end
      return v;
   endfunction

   function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [1:0] sz,
                                             input logic [31:0] d, input int sh);
      logic [31:0] mask;
      if (sz == 2'd2) return d;
      mask = ((sz == 2'd0) ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
      return (w & ~mask) | ((d << sh) & mask);
   endfunction

   task automatic run_req(input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] d, input int hold);
      int idx, sh, lat, exp_lat, rd_cnt, wr_cnt, both_cnt;
      logic f, seen;
      logic [31:0] exp_rd;
      f = ref_fault(sz, a);
      idx = int'(a[MemAddrWidth+1:2]);
      sh = 8 * int'(a[1:0]);
      exp_rd = '0;
      if (!f && !w) exp_rd = ref_load(ref_mem[idx], sz, u, sh);
      if (!f && w) ref_mem[idx] = ref_store(ref_mem[idx], sz, d, sh);
      exp_lat = f ? 1 : ((w && sz != 2'd2) ? 3 : 2);
      if (f) n_faults++;
      else if (w) n_stores++;
      else n_loads++;

      @(negedge clk);
      check_eq("req_ready_idle", 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_write = w; req_size = lsu_size_t'(sz);
      req_unsigned = u; req_addr = a; req_wdata = d;
      rsp_ready = (hold == 0);
      @(posedge clk);
      #1;
      req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
      req_write = $urandom_range(0, 1); req_size = lsu_size_t'($urandom_range(0, 3));

      lat = 0; seen = 1'b0; rd_cnt = 0; wr_cnt = 0; both_cnt = 0;
      for (int i = 1; i <= 8 && !seen; i++) begin
         @(negedge clk);
         if (rsp_valid) begin
            seen = 1'b1;
            lat = i;
         end else begin
            if (mem_out.read == ENABLE) rd_cnt++;
            if (mem_out.write == ENABLE) wr_cnt++;
            if (mem_out.read == ENABLE && mem_out.write == ENABLE) both_cnt++;
         end
      end
      if (!seen) $display("FAIL rsp_timeout: got no response expected one at addr %h", a);
      check_eq("latency", 32'(lat), 32'(exp_lat));
      check_eq("rdata", rsp_rdata, exp_rd);
      check_eq("fault", 32'(rsp_fault), 32'(f));
      check_eq("read_cycles", 32'(rd_cnt), (f || (w && sz == 2'd2)) ? 32'd0 : 32'd1);
      check_eq("write_cycles", 32'(wr_cnt), (!f && w) ? 32'd1 : 32'd0);
      check_eq("rd_wr_overlap", 32'(both_cnt), 32'd0);
      check_eq("resp_rw_idle", 32'({mem_out.read, mem_out.write}), 32'd0);

      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check_eq("hold_valid", 32'(rsp_valid), 32'd1);
         check_eq("hold_rdata", rsp_rdata, exp_rd);
         check_eq("hold_req_ready", 32'(req_ready), 32'd0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      check_eq("release_req_ready", 32'(req_ready), 32'd1);
      check_eq("release_rsp_valid", 32'(rsp_valid), 32'd0);
      rsp_ready = 1'b0;
      if (!f) check_eq("mem_word", env_mem[idx], ref_mem[idx]);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_req_ready"}, 32'(req_ready), 32'd1);
      check_eq({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
      check_eq({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
      check_eq({tag, "_rsp_fault"}, 32'(rsp_fault), 32'd0);
      check_eq({tag, "_mem_rw"}, 32'({mem_out.read, mem_out.write}), 32'd0);
      check_eq({tag, "_mem_addr"}, mem_out.addr, 32'd0);
      check_eq({tag, "_mem_val"}, mem_out.val, 32'd0);
   endtask

   initial begin
      #400000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      logic w, u;
      logic [1:0] sz;
      logic [31:0] a;
      rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = SZ_BYTE;
      req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
      for (int i = 0; i < WORDS; i++) begin
         env_mem[i] = $urandom;
         ref_mem[i] = env_mem[i];
      end
      env_mem[4] = 32'h8899_AABB;
      ref_mem[4] = 32'h8899_AABB;

      #12;
      check_reset_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;

      run_req(1'b0, 2'd0, 1'b0, 32'h11, 32'h0, 0);
      run_req(1'b0, 2'd0, 1'b1, 32'h11, 32'h0, 0);
      run_req(1'b1, 2'd1, 1'b0, 32'h12, 32'h1234, 0);
      check_eq("rmw_half_word", env_mem[4], 32'h1234_AABB);
      run_req(1'b1, 2'd2, 1'b0, 32'h20, 32'hDEAD_BEEF, 0);
      run_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1);
      check_eq("word_store_mem", env_mem[8], 32'hDEAD_BEEF);

      run_req(1'b0, 2'd1, 1'b0, 32'h13, 32'h0, 0);
      run_req(1'b0, 2'd2, 1'b0, 32'h22, 32'h0, 0);
      run_req(1'b0, 2'd3, 1'b0, 32'h40, 32'h0, 0);
      run_req(1'b0, 2'd2, 1'b0, 32'(LIMIT), 32'h0, 0);
      run_req(1'b1, 2'd0, 1'b0, 32'(LIMIT + 5), 32'hFF, 0);

      run_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5);

      // Reset in the middle of a read-modify-write.
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_size = SZ_BYTE;
      req_addr = 32'h31; req_wdata = 32'h5A; rsp_ready = 1'b0;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      check_eq("rmw_rd_read", 32'(mem_out.read), 32'd1);
      #1 rst_n = 1'b0;
      #1 check_reset_outputs("mid_rst");
      n_loads = 0; n_stores = 0; n_faults = 0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check_eq("mid_rst_mem_kept", env_mem[12], ref_mem[12]);

      for (int n = 0; n < 60; n++) begin
         w = 1'($urandom_range(0, 1));
         u = 1'($urandom_range(0, 1));
         sz = 2'($urandom_range(0, 3));
         a = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(LIMIT, 4 * LIMIT))
                                         : 32'($urandom_range(0, LIMIT - 1));
         if ($urandom_range(0, 3) != 0 && sz != 2'd3) a = a & ~((32'd1 << sz) - 32'd1);
         run_req(w, sz, u, a, $urandom, $urandom_range(0, 2));
      end

`ifdef LSU_STATS_EN
      check_eq("stat_loads", 32'(stat_loads), 32'(n_loads));
      check_eq("stat_stores", 32'(stat_stores), 32'(n_stores));
      check_eq("stat_faults", 32'(stat_faults), 32'(n_faults));
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Initiator side of the M memory interface. Accepts load/store requests from the core over a valid/ready handshake and drives the M_input struct (addr, read, write, val). Read data arrives combinationally on M_output.val. Handles byte, halfword and word accesses, using read-modify-write for sub-word stores because M is word-only. Returns sign- or zero-extended load data and an alignment/range fault on a held response handshake.

Parameters:
ADDR_LIMIT, 4*2**MemAddrWidth, byte-address bound; req_addr >= ADDR_LIMIT faults.
CNT_W, 16, width of statistics counters (LSU_STATS_EN only).

Ports:
clk  input  1  system clock.
rst_n  input  1  asynchronous active-low reset.
req_valid  input  1  request present.
req_ready  output  1  unit can accept a request (high only in IDLE).
req_write  input  1  1=store, 0=load.
req_size  input  2  lsu_size_t: 0=byte, 1=half, 2=word, 3=illegal.
req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
req_addr  input  32  byte address.
req_wdata  input  32  store data, right-justified.
rsp_valid  output  1  response held until accepted.
rsp_ready  input  1  consumer accepts response.
rsp_rdata  output  32  extended load data; 0 for stores and faults.
rsp_fault  output  1  misaligned, out-of-range or illegal size; no memory access performed.
mem_out  output  M_input  to M: addr, read, write, val.
mem_in  input  M_output  from M: val.

Behaviour:
- Reset (async, rst_n=0): state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_fault=0. mem_out: read=DISABLE, write=DISABLE, addr=0, val=0. Held request registers cleared.
- States: IDLE, RD, RMW_RD, RMW_WR, WR, RESP.
- IDLE: req_valid&req_ready captures addr, size, wdata, unsigned and write into registers. Fault check happens in the same cycle:
  - half with addr[0]=1 faults.
  - word with addr[1:0]!=0 faults.
  - size=3 faults.
  - addr>=ADDR_LIMIT faults.
  - On fault: go to RESP with fault=1 and no M access.
- Legal request routing: load goes to RD. Word store goes to WR. Byte/half store goes to RMW_RD.
- RD: mem_out.read=ENABLE, addr=held addr with [1:0] forced to 0. Capture mem_in.val at the clock edge. Extract lane addr[1:0] (byte) or addr[1] (half), little-endian, then extend. Go to RESP.
- RMW_RD: read as in RD and capture the word into a merge register. Go to RMW_WR.
- RMW_WR: mem_out.write=ENABLE, val=merge word with only the target lane(s) replaced by wdata[7:0] or wdata[15:0]. Go to RESP.
- WR: mem_out.write=ENABLE, val=wdata. Go to RESP.
- read and write are never both ENABLE. Both are DISABLE in IDLE and RESP.
- RESP: rsp_valid=1 with rdata/fault stable. On rsp_ready go to IDLE (req_ready=1 the next cycle). No overlap of requests.
- Latency from accept edge T to rsp_valid:
  - fault: T+1.
  - load or word store: T+2.
  - sub-word store: T+3.
- rsp_valid and rsp_ready high together at entry to RESP: response consumed after exactly one cycle.
- Reset asserted mid-operation: immediate return to reset values. A pending RMW_WR is dropped and memory is unchanged; a partial write cannot occur because write is only asserted for one cycle in RMW_WR/WR.
- req_valid while busy: ignored (req_ready=0). The requester must hold its request.

Optional Feature:
LSU_STATS_EN: adds outputs stat_loads, stat_stores and stat_faults (each CNT_W wide).
- Each counter increments on completion of the corresponding access, at RESP entry. stat_faults counts faults only; faulting requests are not counted as loads or stores.
- Counters saturate at all-ones and reset to 0.
- Without the macro: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- definitions package: M_input, M_output, ENABLE/DISABLE, MemAddrWidth (existing). Add lsu_size_t enum and lsu_state_t enum.
- Sub-module lsu_lane_align (combinational):
  - load path: lane extract plus sign/zero extend.
  - store path: lane merge of wdata into a 32-bit word.
  - Instantiated once and used by RD and RMW_WR.

Test Plan:
- M word 0x10 = 0x8899AABB. Load byte at 0x11, signed: rsp_rdata=0xFFFFFFAA at T+2. Same access unsigned: 0x000000AA.
- Store half 0x1234 at 0x12 over 0x8899AABB: RMW_RD then RMW_WR; M word becomes 0x1234AABB; rsp at T+3, fault=0.
- Store word 0xDEADBEEF at 0x20, then load word 0x20: returns 0xDEADBEEF. mem_out.write=ENABLE for exactly one cycle.
- Load half at 0x13, word at 0x22, size=3, and addr=ADDR_LIMIT: each gives rsp_fault=1 at T+1, rdata=0, read and write never ENABLE.
- Hold rsp_ready=0 for 5 cycles: rsp_valid and rdata stable, req_ready=0. Assert rsp_ready: req_ready=1 next cycle.
- Assert rst_n=0 during RMW_RD: outputs go to reset values asynchronously; target memory word is unchanged after reset release.
